// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage and the ALU: opcodes, widths,
// instruction field positions and small decode helpers.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 7;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned IMM_W  = 12;

    // Instruction field bit positions (least significant bit of each field)
    localparam int unsigned OP_LSB      = 28;
    localparam int unsigned RD_LSB      = 23;
    localparam int unsigned RS1_LSB     = 18;
    localparam int unsigned RS2_LSB     = 13;
    localparam int unsigned IMM_SEL_BIT = 12;
    localparam int unsigned IMM_LSB     = 0;

    // Op-select codes shared with the ALU; values 5..15 are undefined
    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_XOR = 4'd2,
        OP_OR  = 4'd3,
        OP_AND = 4'd4
    } alu_op_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] rd;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic              imm_sel;
        logic [IMM_W-1:0]  imm;
    } instr_t;

    function automatic instr_t decode_instr(input logic [DATA_W-1:0] w);
        instr_t d;
        d.op      = w[OP_LSB  +: OP_W];
        d.rd      = w[RD_LSB  +: ADDR_W];
        d.rs1     = w[RS1_LSB +: ADDR_W];
        d.rs2     = w[RS2_LSB +: ADDR_W];
        d.imm_sel = w[IMM_SEL_BIT];
        d.imm     = w[IMM_LSB +: IMM_W];
        return d;
    endfunction

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return op <= OP_AND;
    endfunction

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    function automatic logic [CTRL_W-1:0] op_to_ctrl(input logic [OP_W-1:0] op);
        return {{(CTRL_W-OP_W){1'b0}}, op};
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: two combinational read ports with same-cycle write-back
// bypass, one synchronous write port, r0 fixed at zero, async clear.
module regfile_2r1w
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // Storage: cleared on reset, written on any write-back not aimed at r0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && wr_addr != '0) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Port A read: r0 is zero, a same-cycle write to the address wins
    always_comb begin
        ra_data = '0;
        if (ra_addr != '0) begin
            if (wr_en && wr_addr == ra_addr) ra_data = wr_data;
            else                             ra_data = mem[ra_addr];
        end
    end

    // Port B read: same rules as port A
    always_comb begin
        rb_data = '0;
        if (rb_addr != '0) begin
            if (wr_en && wr_addr == rb_addr) rb_data = wr_data;
            else                             rb_data = mem[rb_addr];
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage ahead of the ALU: decodes instruction words, reads
// operands, tracks in-flight destinations in a busy scoreboard and hands
// ops to the ALU through a registered valid/ready slot.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_instr,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_a,
    output logic [DATA_W-1:0]      out_b,
    output logic [ADDR_W-1:0]      out_rd,
    input  logic                   wb_en,
    input  logic [ADDR_W-1:0]      wb_addr,
    input  logic [DATA_W-1:0]      wb_data,
    output logic                   illegal_op,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    instr_t              dec;
    logic                legal;
    logic                slot_free;
    logic                hazard;
    logic                accept;
    logic                issue;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_eff;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] wb_clr;
    logic [DATA_W-1:0]   rs1_val;
    logic [DATA_W-1:0]   rs2_val;
    logic [DATA_W-1:0]   opnd_b;

    assign dec   = decode_instr(in_instr);
    assign legal = op_is_legal(dec.op);

    regfile_2r1w #(
        .NUM_REGS (NUM_REGS)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (dec.rs1),
        .ra_data (rs1_val),
        .rb_addr (dec.rs2),
        .rb_data (rs2_val),
        .wr_en   (wb_en),
        .wr_addr (wb_addr),
        .wr_data (wb_data)
    );

    // One-hot mask of the scoreboard bit released by this cycle's write-back
    always_comb begin
        wb_clr = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (wb_en && wb_addr == ADDR_W'(i)) wb_clr[i] = 1'b1;
        end
    end

    assign busy_eff = busy & ~wb_clr;

    // Hazard check against effective busy bits; busy[0] is always clear
    always_comb begin
        hazard = busy_eff[dec.rs1] | busy_eff[dec.rd];
        if (!dec.imm_sel) hazard = hazard | busy_eff[dec.rs2];
    end

    assign slot_free = !out_valid || out_ready;
    // Illegal words are dropped without issuing, so hazards cannot block them
    assign in_ready  = slot_free && (!legal || !hazard);
    assign accept    = in_valid && in_ready;
    assign issue     = accept && legal;
    assign opnd_b    = dec.imm_sel ? sext_imm(dec.imm) : rs2_val;

    // Next scoreboard: release on write-back, then set on issue so set wins
    always_comb begin
        busy_next = busy_eff;
        if (issue && dec.rd != '0) busy_next[dec.rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_next;
    end

    // Output slot: load on issue, drop when consumed with nothing to replace it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_rd    <= '0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_ctrl  <= op_to_ctrl(dec.op);
            out_a     <= rs1_val;
            out_b     <= opnd_b;
            out_rd    <= dec.rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Illegal-opcode pulse for the cycle after the word is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_op <= 1'b0;
        else        illegal_op <= accept && !legal;
    end

    // Saturating count of cycles a presented word was held off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed words push hand-computed
// expected slot contents; a monitor pops and compares on each consumption.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_ctrl;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_rd;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        illegal_op;
    logic [15:0] stall_cnt;

    typedef struct {
        logic [6:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    alu_issue_stage #(
        .NUM_REGS    (32),
        .STALL_CNT_W (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_rd     (out_rd),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .illegal_op (illegal_op),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic isel, input logic [11:0] imm);
        return {op, rd, rs1, rs2, isel, imm};
    endfunction

    function automatic exp_t ex(input logic [6:0] c, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd);
        exp_t e;
        e.ctrl = c; e.a = a; e.b = b; e.rd = rd;
        return e;
    endfunction

    // Monitor: every slot consumption must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got rd=%0d with no expected entry, expected none", out_rd);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_ctrl", {25'd0, out_ctrl}, {25'd0, e.ctrl});
                check("out_a", out_a, e.a);
                check("out_b", out_b, e.b);
                check("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] addr, input logic [31:0] data);
        wb_en = 1'b1; wb_addr = addr; wb_data = data;
        tick();
        wb_en = 1'b0;
    endtask

    // Present a word until accepted (bounded), pushing its expected slot
    task automatic issue(input logic [31:0] w, input exp_t e, output int waited);
        in_valid = 1'b1;
        in_instr = w;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got in_ready=0 after %0d cycles, expected 1", waited);
        end else begin
            exp_q.push_back(e);
        end
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time limit, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;

        // Reset state
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_ctrl", {25'd0, out_ctrl}, 32'd0);
        check("rst_out_a", out_a, 32'd0);
        check("rst_out_b", out_b, 32'd0);
        check("rst_out_rd", {27'd0, out_rd}, 32'd0);
        check("rst_illegal", {31'd0, illegal_op}, 32'd0);
        check("rst_stall", {16'd0, stall_cnt}, 32'd0);
        #5 rst_n = 1'b1;
        tick();

        // Basic issue: r1=5, r2=7, add r3 = r1 + r2
        wb(5'd1, 32'd5);
        wb(5'd2, 32'd7);
        out_ready = 1'b1;
        issue(mk(4'd0, 5'd3, 5'd1, 5'd2, 1'b0, 12'd0), ex(7'd0, 32'd5, 32'd7, 5'd3), w);

        // RAW on r3: stalls, then same-cycle write-back releases it
        in_valid = 1'b1;
        in_instr = mk(4'd1, 5'd4, 5'd3, 5'd2, 1'b0, 12'd0);
        @(negedge clk);
        check("raw_ready_0", {31'd0, in_ready}, 32'd0);
        check("raw_stall_0", {16'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        check("raw_ready_1", {31'd0, in_ready}, 32'd0);
        check("raw_stall_1", {16'd0, stall_cnt}, 32'd1);
        tick();
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'd12;
        @(negedge clk);
        check("raw_bypass_ready", {31'd0, in_ready}, 32'd1);
        check("raw_stall_2", {16'd0, stall_cnt}, 32'd2);
        if (in_ready) exp_q.push_back(ex(7'd1, 32'd12, 32'd7, 5'd4));
        tick();
        in_valid = 1'b0;
        wb_en = 1'b0;

        // Immediate: or r5 = r1 | sext(FFF); rs2=r4 is busy but ignored
        issue(mk(4'd3, 5'd5, 5'd1, 5'd4, 1'b1, 12'hFFF), ex(7'd3, 32'd5, 32'hFFFF_FFFF, 5'd5), w);
        check("imm_no_stall", w, 32'd0);
        tick();

        // Backpressure: hold xor for 3 cycles, then replace with and
        out_ready = 1'b0;
        issue(mk(4'd2, 5'd6, 5'd1, 5'd2, 1'b0, 12'd0), ex(7'd2, 32'd5, 32'd7, 5'd6), w);
        in_valid = 1'b1;
        in_instr = mk(4'd4, 5'd7, 5'd2, 5'd1, 1'b0, 12'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_ctrl", {25'd0, out_ctrl}, 32'd2);
            check("bp_a", out_a, 32'd5);
            check("bp_b", out_b, 32'd7);
            check("bp_rd", {27'd0, out_rd}, 32'd6);
        end
        tick();
        out_ready = 1'b1;
        issue(mk(4'd4, 5'd7, 5'd2, 5'd1, 1'b0, 12'd0), ex(7'd4, 32'd7, 32'd5, 5'd7), w);
        check("bp_replace_no_wait", w, 32'd0);
        check("bp_no_bubble", {31'd0, out_valid}, 32'd1);
        tick();
        tick();

        // Illegal opcode with busy rd=r4: consumed anyway, pulse, no output
        in_valid = 1'b1;
        in_instr = mk(4'hA, 5'd4, 5'd1, 5'd2, 1'b0, 12'd0);
        @(negedge clk);
        check("ill_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("ill_pulse", {31'd0, illegal_op}, 32'd1);
        check("ill_no_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("ill_pulse_end", {31'd0, illegal_op}, 32'd0);
        check("ill_still_no_valid", {31'd0, out_valid}, 32'd0);
        tick();

        // r0: writes ignored, reads zero, rd=0 never marks busy
        wb(5'd0, 32'd99);
        issue(mk(4'd0, 5'd0, 5'd0, 5'd1, 1'b0, 12'd0), ex(7'd0, 32'd0, 32'd5, 5'd0), w);
        issue(mk(4'd0, 5'd0, 5'd1, 5'd0, 1'b0, 12'd0), ex(7'd0, 32'd5, 32'd0, 5'd0), w);
        check("r0_no_busy", w, 32'd0);
        tick();

        // Async reset mid-operation with slot held and r3/r9 busy
        issue(mk(4'd0, 5'd3, 5'd1, 5'd1, 1'b0, 12'd0), ex(7'd0, 32'd5, 32'd5, 5'd3), w);
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = mk(4'd1, 5'd9, 5'd1, 5'd2, 1'b0, 12'd0);
        @(negedge clk);
        check("pre_rst_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_ctrl", {25'd0, out_ctrl}, 32'd0);
        check("arst_out_a", out_a, 32'd0);
        check("arst_out_b", out_b, 32'd0);
        check("arst_out_rd", {27'd0, out_rd}, 32'd0);
        check("arst_stall", {16'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        issue(mk(4'd1, 5'd10, 5'd3, 5'd1, 1'b0, 12'd0), ex(7'd1, 32'd0, 32'd0, 5'd10), w);
        check("post_rst_no_hazard", w, 32'd0);
        tick();
        tick();

        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
